// File: rtl/adjmat_arbiter_if.sv
// Requester/AdjMat bus bundle for adjmat_arbiter. master = requesters + AdjMat
// side (testbench or Container), slave = the arbiter itself.
`ifndef PRED_WIDTH
`define PRED_WIDTH 4
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

interface adjmat_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = `PRED_WIDTH + 1,
    parameter int DATA_W = `WEIGHT_WIDTH + 1
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_row;
    logic [NREQ*ADDR_W-1:0] req_col;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic [ADDR_W-1:0]      adjmat_row_addr;
    logic [ADDR_W-1:0]      adjmat_col_addr;
    logic [DATA_W-1:0]      adjmat_data;
    logic                   adjmat_we;
    logic [DATA_W-1:0]      adjmat_q;

    modport master (
        output req, req_lock, req_we, req_row, req_col, req_wdata, adjmat_q,
        input  gnt, rvalid, rdata, adjmat_row_addr, adjmat_col_addr, adjmat_data, adjmat_we
    );

    modport slave (
        input  req, req_lock, req_we, req_row, req_col, req_wdata, adjmat_q,
        output gnt, rvalid, rdata, adjmat_row_addr, adjmat_col_addr, adjmat_data, adjmat_we
    );
endinterface

// File: rtl/adjmat_arbiter.sv
// Round-robin arbiter with burst lock sharing the single AdjMat port.
// Optional grant/conflict statistics enabled by defining ADJMAT_ARB_STATS_EN.
module adjmat_arbiter #(
    parameter int NREQ     = 3,
    parameter int ADDR_W   = `PRED_WIDTH + 1,
    parameter int DATA_W   = `WEIGHT_WIDTH + 1,
    parameter int MAX_LOCK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    adjmat_arbiter_if.slave      bus
`ifdef ADJMAT_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_grants,
    output logic [15:0]          stat_conflicts
`endif
);
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LOCK_W = $clog2(MAX_LOCK + 1);
    localparam logic [LOCK_W-1:0] LOCK_LIMIT = LOCK_W'(MAX_LOCK);
    localparam logic [NREQ-1:0]   REQ_ONE    = NREQ'(1);

    logic [IDX_W-1:0]  r_lastWinner;
    logic              r_lockActive;
    logic [LOCK_W-1:0] r_lockCount;
    logic [ADDR_W-1:0] r_rowAddr;
    logic [ADDR_W-1:0] r_colAddr;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic [NREQ-1:0]   r_rdPipe1;
    logic [NREQ-1:0]   r_rdPipe2;

    logic              w_winValid;
    logic [IDX_W-1:0]  w_winIdx;
    logic              w_forced;
    logic [NREQ-1:0]   w_gnt;

    // Locked owner keeps the port until it drops req or exhausts MAX_LOCK;
    // otherwise scan from last winner + 1, which puts an expired owner last.
    always_comb begin
        w_winValid = 1'b0;
        w_winIdx   = '0;
        w_forced   = 1'b0;
        if (r_lockActive && bus.req[r_lastWinner] && (r_lockCount < LOCK_LIMIT)) begin
            w_winValid = 1'b1;
            w_winIdx   = r_lastWinner;
        end else begin
            w_forced = r_lockActive && (r_lockCount >= LOCK_LIMIT);
            for (int k = 1; k <= NREQ; k++) begin
                if (!w_winValid && bus.req[(int'(r_lastWinner) + k) % NREQ]) begin
                    w_winValid = 1'b1;
                    w_winIdx   = IDX_W'((int'(r_lastWinner) + k) % NREQ);
                end
            end
        end
    end

    assign w_gnt = (reset && w_winValid) ? (REQ_ONE << w_winIdx) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lastWinner <= IDX_W'(NREQ - 1);
            r_lockActive <= 1'b0;
            r_lockCount  <= '0;
            r_rowAddr    <= '0;
            r_colAddr    <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_rdPipe1    <= '0;
            r_rdPipe2    <= '0;
        end else begin
            r_we      <= 1'b0;
            r_rdPipe1 <= '0;
            r_rdPipe2 <= r_rdPipe1;
            if (r_lockActive && !bus.req[r_lastWinner]) begin
                r_lockActive <= 1'b0;
                r_lockCount  <= '0;
            end
            if (w_winValid) begin
                r_lastWinner <= w_winIdx;
                r_rowAddr    <= bus.req_row[w_winIdx*ADDR_W +: ADDR_W];
                r_colAddr    <= bus.req_col[w_winIdx*ADDR_W +: ADDR_W];
                r_data       <= bus.req_wdata[w_winIdx*DATA_W +: DATA_W];
                r_we         <= bus.req_we[w_winIdx];
                r_rdPipe1    <= bus.req_we[w_winIdx] ? '0 : w_gnt;
                if (w_forced || !bus.req_lock[w_winIdx]) begin
                    r_lockActive <= 1'b0;
                    r_lockCount  <= '0;
                end else begin
                    r_lockActive <= 1'b1;
                    r_lockCount  <= (r_lockActive && (w_winIdx == r_lastWinner))
                                    ? r_lockCount + LOCK_W'(1) : LOCK_W'(1);
                end
            end
        end
    end

    assign bus.gnt             = w_gnt;
    assign bus.rvalid          = r_rdPipe2;
    assign bus.rdata           = bus.adjmat_q;
    assign bus.adjmat_row_addr = r_rowAddr;
    assign bus.adjmat_col_addr = r_colAddr;
    assign bus.adjmat_data     = r_data;
    assign bus.adjmat_we       = r_we;

`ifdef ADJMAT_ARB_STATS_EN
    logic [NREQ*16-1:0] r_statGrants;
    logic [15:0]        r_statConflicts;
    logic               w_multiReq;

    // Clearing the lowest set bit leaves something only when two or more requesters ask.
    assign w_multiReq = |(bus.req & (bus.req - REQ_ONE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_statGrants    <= '0;
            r_statConflicts <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt[i] && (r_statGrants[i*16 +: 16] != 16'hFFFF))
                    r_statGrants[i*16 +: 16] <= r_statGrants[i*16 +: 16] + 16'd1;
            end
            if (w_multiReq && (r_statConflicts != 16'hFFFF))
                r_statConflicts <= r_statConflicts + 16'd1;
        end
    end

    assign stat_grants    = r_statGrants;
    assign stat_conflicts = r_statConflicts;
`endif
endmodule

// File: tb/tb_adjmat_arbiter.sv
// Directed testbench for adjmat_arbiter with a 1-cycle synchronous AdjMat model.
// Statistics checks are compiled only when ADJMAT_ARB_STATS_EN is defined.
`ifndef PRED_WIDTH
`define PRED_WIDTH 4
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

module tb_adjmat_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = `PRED_WIDTH + 1;
    localparam int DATA_W = `WEIGHT_WIDTH + 1;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    adjmat_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ADJMAT_ARB_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
    logic [15:0]        stat_conflicts;
`endif

    adjmat_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef ADJMAT_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AdjMat model: read-before-write synchronous RAM, q valid one cycle after the address.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1][0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.adjmat_we)
            mem[bus.adjmat_row_addr][bus.adjmat_col_addr] <= bus.adjmat_data;
        bus.adjmat_q <= mem[bus.adjmat_row_addr][bus.adjmat_col_addr];
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearReqs();
        bus.req       = '0;
        bus.req_lock  = '0;
        bus.req_we    = '0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        bus.req_wdata = '0;
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic lock,
                                 input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col,
                                 input logic [DATA_W-1:0] wdata);
        bus.req[idx]                       = 1'b1;
        bus.req_we[idx]                    = we;
        bus.req_lock[idx]                  = lock;
        bus.req_row[idx*ADDR_W +: ADDR_W]  = row;
        bus.req_col[idx*ADDR_W +: ADDR_W]  = col;
        bus.req_wdata[idx*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearReqs();
        nextCycle();
        nextCycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clearReqs();
        nextCycle();
        bus.req = 3'b111;
        #1;
        compared++;
        if (bus.gnt !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_gnt: got %b expected %b", bus.gnt, 3'b000);
        end
        nextCycle();
        compared++;
        if (bus.adjmat_we !== 1'b0 || bus.adjmat_row_addr !== '0 || bus.adjmat_col_addr !== '0
            || bus.adjmat_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_port: got we=%b row=%0h col=%0h data=%0h expected all 0",
                     bus.adjmat_we, bus.adjmat_row_addr, bus.adjmat_col_addr, bus.adjmat_data);
        end
        compared++;
        if (bus.rvalid !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_rvalid: got %b expected %b", bus.rvalid, 3'b000);
        end
        clearReqs();
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0]   expGnt [0:3];
        logic [ADDR_W-1:0] expRow [0:3];
        expGnt = '{3'b001, 3'b010, 3'b100, 3'b001};
        expRow = '{5'd1, 5'd2, 5'd3, 5'd1};
        doReset();
        for (int k = 0; k < 6; k++) begin
            clearReqs();
            if (k < 4)
                for (int i = 0; i < NREQ; i++)
                    applyStimulus(i, 1'b0, 1'b0, ADDR_W'(i + 1), ADDR_W'(i + 10), '0);
            #1;
            compared++;
            if (bus.gnt !== ((k < 4) ? expGnt[k] : 3'b000)) begin
                mismatched++;
                $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, bus.gnt,
                         (k < 4) ? expGnt[k] : 3'b000);
            end
            if (k >= 1 && k <= 4) begin
                compared++;
                if (bus.adjmat_row_addr !== expRow[k-1]) begin
                    mismatched++;
                    $display("[TB] FAIL rr_row[%0d]: got %0d expected %0d", k,
                             bus.adjmat_row_addr, expRow[k-1]);
                end
            end
            if (k >= 2) begin
                compared++;
                if (bus.rvalid !== expGnt[k-2]) begin
                    mismatched++;
                    $display("[TB] FAIL rr_rvalid[%0d]: got %b expected %b", k, bus.rvalid,
                             expGnt[k-2]);
                end
            end
            nextCycle();
        end
    endtask

    task automatic test_read();
        clearReqs();
        applyStimulus(0, 1'b1, 1'b0, 5'd2, 5'd5, 16'h1234);
        #1;
        compared++;
        if (bus.gnt !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL preload_gnt: got %b expected %b", bus.gnt, 3'b001);
        end
        nextCycle();
        clearReqs();
        applyStimulus(1, 1'b0, 1'b0, 5'd2, 5'd5, '0);
        #1;
        compared++;
        if (bus.gnt !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL read_gnt: got %b expected %b", bus.gnt, 3'b010);
        end
        nextCycle();
        clearReqs();
        #1;
        compared++;
        if (bus.adjmat_row_addr !== 5'd2 || bus.adjmat_col_addr !== 5'd5 || bus.adjmat_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_issue: got row=%0d col=%0d we=%b expected 2 5 0",
                     bus.adjmat_row_addr, bus.adjmat_col_addr, bus.adjmat_we);
        end
        compared++;
        if (bus.rvalid !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL read_early_rvalid: got %b expected %b", bus.rvalid, 3'b000);
        end
        nextCycle();
        compared++;
        if (bus.rvalid !== 3'b010 || bus.rdata !== 16'h1234) begin
            mismatched++;
            $display("[TB] FAIL read_data: got rvalid=%b rdata=%h expected 010 1234",
                     bus.rvalid, bus.rdata);
        end
        nextCycle();
        compared++;
        if (bus.rvalid !== 3'b000 || bus.adjmat_row_addr !== 5'd2) begin
            mismatched++;
            $display("[TB] FAIL read_idle: got rvalid=%b row=%0d expected 000 2",
                     bus.rvalid, bus.adjmat_row_addr);
        end
    endtask

    task automatic test_write_then_read();
        clearReqs();
        applyStimulus(0, 1'b1, 1'b0, 5'd3, 5'd4, 16'hBEEF);
        #1;
        compared++;
        if (bus.gnt !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL wr_gnt: got %b expected %b", bus.gnt, 3'b001);
        end
        nextCycle();
        clearReqs();
        applyStimulus(2, 1'b0, 1'b0, 5'd3, 5'd4, '0);
        #1;
        compared++;
        if (bus.gnt !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL rd_after_wr_gnt: got %b expected %b", bus.gnt, 3'b100);
        end
        compared++;
        if (bus.adjmat_we !== 1'b1 || bus.adjmat_data !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL wr_issue: got we=%b data=%h expected 1 beef",
                     bus.adjmat_we, bus.adjmat_data);
        end
        nextCycle();
        clearReqs();
        #1;
        compared++;
        if (bus.rvalid !== 3'b000 || bus.adjmat_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wr_no_rvalid: got rvalid=%b we=%b expected 000 0",
                     bus.rvalid, bus.adjmat_we);
        end
        nextCycle();
        compared++;
        if (bus.rvalid !== 3'b100 || bus.rdata !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL rd_after_wr_data: got rvalid=%b rdata=%h expected 100 beef",
                     bus.rvalid, bus.rdata);
        end
        nextCycle();
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] exp;
        doReset();
        for (int k = 0; k < 11; k++) begin
            clearReqs();
            applyStimulus(0, 1'b0, 1'b0, 5'd0, 5'd0, '0);
            applyStimulus(1, 1'b0, 1'b0, 5'd1, 5'd1, '0);
            applyStimulus(2, 1'b0, 1'b1, 5'd2, 5'd2, '0);
            exp = (k == 0 || k == 10) ? 3'b001 : (k == 1) ? 3'b010 : 3'b100;
            #1;
            compared++;
            if (bus.gnt !== exp) begin
                mismatched++;
                $display("[TB] FAIL lock_gnt[%0d]: got %b expected %b", k, bus.gnt, exp);
            end
            nextCycle();
        end
        clearReqs();
    endtask

    task automatic test_reset_midread();
        clearReqs();
        applyStimulus(1, 1'b0, 1'b0, 5'd2, 5'd5, '0);
        #1;
        compared++;
        if (bus.gnt !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL midread_gnt: got %b expected %b", bus.gnt, 3'b010);
        end
        nextCycle();
        reset = 1'b0;
        clearReqs();
        bus.req = 3'b110;
        #1;
        compared++;
        if (bus.gnt !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL midread_reset_gnt: got %b expected %b", bus.gnt, 3'b000);
        end
        nextCycle();
        reset = 1'b1;
        clearReqs();
        applyStimulus(1, 1'b0, 1'b0, 5'd1, 5'd1, '0);
        applyStimulus(2, 1'b0, 1'b0, 5'd2, 5'd2, '0);
        #1;
        compared++;
        if (bus.rvalid !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL midread_rvalid: got %b expected %b", bus.rvalid, 3'b000);
        end
        compared++;
        if (bus.gnt !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL post_reset_gnt: got %b expected %b", bus.gnt, 3'b010);
        end
        nextCycle();
        clearReqs();
        nextCycle();
    endtask

`ifdef ADJMAT_ARB_STATS_EN
    task automatic test_stats();
        doReset();
        for (int k = 0; k < 10; k++) begin
            clearReqs();
            applyStimulus(0, 1'b0, 1'b0, 5'd0, 5'd0, '0);
            applyStimulus(1, 1'b0, 1'b0, 5'd1, 5'd1, '0);
            nextCycle();
        end
        clearReqs();
        nextCycle();
        compared++;
        if (stat_grants !== {16'd0, 16'd5, 16'd5}) begin
            mismatched++;
            $display("[TB] FAIL stat_grants: got %h expected %h", stat_grants, {16'd0, 16'd5, 16'd5});
        end
        compared++;
        if (stat_conflicts !== 16'd10) begin
            mismatched++;
            $display("[TB] FAIL stat_conflicts: got %0d expected %0d", stat_conflicts, 10);
        end
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        clearReqs();
        #1;
        test_reset();
        test_round_robin();
        test_read();
        test_write_then_read();
        test_lock();
        test_reset_midread();
`ifdef ADJMAT_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
